// File: rtl/ps2_host_tx_if.sv
// if_wb: minimal Wishbone classic bus bundle.
//   cyc, stb, we   - cycle, strobe and write-enable from the master
//   adr, dat_i     - address and write data from the master
//   dat_o, ack     - read data and single-cycle acknowledge from the slave
//   stall          - pipelined-mode stall from the slave
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        stall;

  modport slave (
    input  cyc, stb, we, adr, dat_i,
    output dat_o, ack, stall
  );

  modport master (
    output cyc, stb, we, adr, dat_i,
    input  dat_o, ack, stall
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter with a Wishbone slave port.
// Software writes a command byte at adr[2]=0 and polls status at adr[2]=1.
// The block inhibits the bus, issues the start bit, shifts out 8 data bits,
// odd parity and stop on device-generated falling clock edges, then samples
// the device ack bit. tx_busy lets the receive path ignore our own traffic.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous reset, active low
//   bus           Wishbone slave (cyc, stb, we, adr[2], dat_i[7:0], dat_o, ack, stall)
//   ps2_clock     PS/2 clock pad input (asynchronous)
//   ps2_data      PS/2 data pad input (asynchronous)
//   ps2_clock_oe  1 = pull PS/2 clock low
//   ps2_data_oe   1 = pull PS/2 data low
//   tx_busy       transmit FSM not idle
//
// state     | meaning
// S_IDLE    | lines released, waiting for a byte
// S_INHIBIT | clock held low for INHIBIT_CYCLES
// S_SEND    | start bit on the line, shifting data/parity/stop on falling edges
// S_ACK     | data released, next falling edge samples the device ack
// S_DONE    | waiting for the device to release the clock
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  if_wb.slave  bus,
  input  logic ps2_clock,
  input  logic ps2_data,
  output logic ps2_clock_oe,
  output logic ps2_data_oe,
  output logic tx_busy
);

  localparam int unsigned MAX_CYCLES =
    (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] INH_TC = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_TC = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    clk_sync_q;
  logic [2:0]    dat_sync_q;
  logic          clk_fall;

  logic          req_q;
  logic          we_q;
  logic          sel_q;
  logic [7:0]    wdat_q;
  logic          ack_q;
  logic [31:0]   dat_o_q;
  logic [31:0]   rdata;
  logic          wr_go;

  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          ack_ok_q, ack_ok_d;
  logic          nack_q, nack_d;
  logic          timeout_q, timeout_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    last_q, last_d;

  logic          unused_bus;
  assign unused_bus = ^{bus.adr[31:3], bus.adr[1:0], bus.dat_i[31:8]};

  // Pad synchronizers; reset to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clock};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
    end
  end

  assign clk_fall = (clk_sync_q[2:1] == 2'b10);

  // Wishbone: latch the request, answer one cycle later. A new request is
  // not taken while one is pending or being acked, since the master keeps
  // stb high until it sees ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      wdat_q  <= 8'h00;
      ack_q   <= 1'b0;
      dat_o_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      if (req_q) begin
        req_q   <= 1'b0;
        ack_q   <= 1'b1;
        dat_o_q <= rdata;
      end else if (bus.cyc && bus.stb && !ack_q) begin
        req_q  <= 1'b1;
        we_q   <= bus.we;
        sel_q  <= bus.adr[2];
        wdat_q <= bus.dat_i[7:0];
      end
    end
  end

  // Read data comes from current register values, so a read that lands on
  // a flag update returns the value before the update.
  assign rdata = sel_q ? {27'h0, overrun_q, timeout_q, nack_q, ack_ok_q, tx_busy}
                       : {24'h0, last_q};

  assign wr_go     = req_q && we_q && !sel_q;
  assign bus.ack   = ack_q;
  assign bus.dat_o = dat_o_q;
  assign bus.stall = 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      shreg_q   <= 10'h0;
      cnt_q     <= 4'h0;
      timer_q   <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      last_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ack_ok_q  <= ack_ok_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_ok_d  = ack_ok_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    last_d    = last_q;

    if (wr_go) begin
      if (state_q == S_IDLE) begin
        last_d    = wdat_q;
        shreg_d   = {1'b1, ~^wdat_q, wdat_q};
        ack_ok_d  = 1'b0;
        nack_d    = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        cnt_d     = 4'h0;
        timer_d   = '0;
        clk_oe_d  = 1'b1;
        dat_oe_d  = 1'b0;
        state_d   = S_INHIBIT;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
      end

      S_INHIBIT: begin
        if (timer_q == INH_TC) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = S_SEND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_SEND, S_ACK, S_DONE: begin
        // Terminal count has priority over a coincident clock edge.
        if (timer_q == TMO_TC) begin
          timeout_d = 1'b1;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
          if (state_q == S_SEND) begin
            if (clk_fall) begin
              dat_oe_d = ~shreg_q[0];
              shreg_d  = {1'b0, shreg_q[9:1]};
              cnt_d    = cnt_q + 4'd1;
              if (cnt_q == 4'd9) begin
                state_d = S_ACK;
              end
            end
          end else if (state_q == S_ACK) begin
            dat_oe_d = 1'b0;
            if (clk_fall) begin
              ack_ok_d = ~dat_sync_q[2];
              nack_d   = dat_sync_q[2];
              state_d  = S_DONE;
            end
          end else begin
            if (clk_sync_q[2]) begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ps2_clock_oe = clk_oe_q;
  assign ps2_data_oe  = dat_oe_q;
  assign tx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TMO = 1500;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  if_wb wb();

  logic ps2_clock_oe, ps2_data_oe, tx_busy;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clock, ps2_data;

  // Open-drain wiring: line is low if either side pulls it.
  assign ps2_clock = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (wb),
    .ps2_clock    (ps2_clock),
    .ps2_data     (ps2_data),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_busy      (tx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dev_edges = 0;
  int inh_run = 0;
  int last_inhibit = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference frame as seen on the data line for edges 1..10.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  // Length of the most recent run of clock inhibit.
  initial forever begin
    tick();
    if (ps2_clock_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inhibit = inh_run;
      inh_run = 0;
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    int lat = 0;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.dat_i = wdata;
    do begin
      tick();
      lat++;
    end while (!wb.ack && lat < 20);
    check("ack_latency", lat, 2);
    rdata = wb.dat_o;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    tick();
    check("ack_pulse", {31'h0, wb.ack}, 0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, data, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
    wb_xfer(1'b0, adr, 32'h0, data);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!(ps2_data_oe && !ps2_clock_oe) && n < INH + 50) begin
      tick();
      n++;
    end
    check("start_bit", {30'h0, ps2_data_oe, ps2_clock_oe}, 32'h2);
  endtask

  task automatic dev_clock(input int half, output logic seen);
    dev_clk_low = 1'b1;
    dev_edges++;
    repeat (half) tick();
    seen = ps2_data;
    dev_clk_low = 1'b0;
    repeat (half) tick();
  endtask

  // Device side of one frame: clock out 10 bits, then drive the ack bit
  // and issue edge 11 (optionally leaving the clock stuck low).
  task automatic device_frame(input logic [7:0] b, input logic ack_bit, input int half,
                              input logic stuck);
    logic [9:0] seen;
    logic s;
    wait_start();
    repeat (3) tick();
    for (int e = 0; e < 10; e++) begin
      dev_clock(half, s);
      seen[e] = s;
    end
    check("frame_bits", {22'h0, seen}, {22'h0, exp_frame(b)});
    dev_data_low = ~ack_bit;
    repeat (4) tick();
    if (!stuck) dev_clock(half, s);
    else begin
      dev_clk_low = 1'b1;
      dev_edges++;
      repeat (half) tick();
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (tx_busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_wait", {31'h0, tx_busy}, 0);
  endtask

  logic [31:0] rd;
  logic [7:0]  b;
  logic        ab;
  int          half;

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = 32'h0; wb.dat_i = 32'h0;
    repeat (3) tick();
    check("reset_oe", {30'h0, ps2_clock_oe, ps2_data_oe}, 0);
    check("reset_busy", {31'h0, tx_busy}, 0);
    rst_i = 1'b1;
    tick();
    check("stall", {31'h0, wb.stall}, 0);
    wb_read(32'h4, rd); check("reset_status", rd, 32'h0);
    wb_read(32'h0, rd); check("reset_data", rd, 32'h0);

    // LED command with device ack
    wb_write(32'h0, 32'hED);
    device_frame(8'hED, 1'b0, 20, 1'b0);
    wait_idle(200);
    check("inhibit_len", last_inhibit, INH);
    wb_read(32'h4, rd); check("status_ack_ed", rd, 32'h02);

    // Device nack, parity bit 0
    wb_write(32'h0, 32'h01);
    device_frame(8'h01, 1'b1, 20, 1'b0);
    wait_idle(200);
    wb_read(32'h4, rd); check("status_nack", rd, 32'h04);

    // Status register write has no effect
    wb_write(32'h4, 32'h1F);
    check("status_wr_busy", {31'h0, tx_busy}, 0);
    wb_read(32'h4, rd); check("status_wr_noeffect", rd, 32'h04);

    // Device never clocks
    wb_write(32'h0, 32'hFF);
    repeat (INH + TMO - 10) tick();
    check("pre_timeout_busy", {31'h0, tx_busy}, 1);
    check("pre_timeout_start", {31'h0, ps2_data_oe}, 1);
    repeat (20) tick();
    check("timeout_busy", {31'h0, tx_busy}, 0);
    check("timeout_oe", {30'h0, ps2_clock_oe, ps2_data_oe}, 0);
    wb_read(32'h4, rd); check("status_timeout", rd, 32'h08);

    // Overrun: write during edge 4 of an active frame
    b = 8'($urandom);
    wb_write(32'h0, {24'h0, b});
    dev_edges = 0;
    fork
      device_frame(b, 1'b0, 20, 1'b0);
      begin
        int n = 0;
        while (dev_edges < 4 && n < 2000) begin
          tick();
          n++;
        end
        wb_write(32'h0, 32'hF3);
      end
    join
    wait_idle(200);
    wb_read(32'h4, rd); check("status_overrun", rd, 32'h12);

    // Readback and status while busy
    wb_write(32'h0, 32'h5A);
    wb_read(32'h0, rd); check("readback_5a", rd, 32'h0000005A);
    wb_read(32'h4, rd); check("status_busy", rd, 32'h01);
    device_frame(8'h5A, 1'b0, 15, 1'b0);
    wait_idle(200);
    wb_read(32'h4, rd); check("status_ack_5a", rd, 32'h02);

    // Clock stuck low after ack: timeout keeps ack_ok
    b = 8'($urandom);
    wb_write(32'h0, {24'h0, b});
    device_frame(b, 1'b0, 20, 1'b1);
    wait_idle(TMO + 200);
    check("done_timeout_oe", {30'h0, ps2_clock_oe, ps2_data_oe}, 0);
    wb_read(32'h4, rd); check("status_done_timeout", rd, 32'h0A);
    dev_clk_low = 1'b0;
    repeat (10) tick();

    // Random frames
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      ab   = 1'($urandom);
      half = int'($urandom_range(8, 25));
      wb_write(32'h0, {24'h0, b});
      device_frame(b, ab, half, 1'b0);
      wait_idle(200);
      wb_read(32'h4, rd); check("rand_status", rd, ab ? 32'h04 : 32'h02);
      wb_read(32'h0, rd); check("rand_readback", rd, {24'h0, b});
    end

    // Reset during edge 5 (data bit 4 = 0, so data is being pulled low)
    b = 8'($urandom) & 8'hEF;
    wb_write(32'h0, {24'h0, b});
    wait_start();
    repeat (3) tick();
    for (int e = 0; e < 4; e++) begin
      logic s;
      dev_clock(20, s);
    end
    dev_clk_low = 1'b1;
    repeat (12) tick();
    check("pre_reset_data_oe", {31'h0, ps2_data_oe}, 1);
    #2 rst_i = 1'b0;
    #1;
    check("reset_async_oe", {30'h0, ps2_clock_oe, ps2_data_oe}, 0);
    check("reset_async_busy", {31'h0, tx_busy}, 0);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    wb_read(32'h4, rd); check("status_after_reset", rd, 32'h0);
    wb_read(32'h0, rd); check("data_after_reset", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes such as LED set (0xED), reset (0xFF) and typematic rate to a keyboard, on the same open-drain clock and data lines that the keyboard receive path listens to.
It is a Wishbone slave. Software writes a byte, then polls status.
The block implements the full host-to-device sequence: inhibit, start, 8 data bits, parity, stop, and device ack detection.
It asserts tx_busy so the keyboard receive path can discard line activity while a transmit is in progress.

Parameters:
INHIBIT_CYCLES, 5000, clk_i cycles the PS/2 clock is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum clk_i cycles from clock release to ack sample before abort (20 ms at 50 MHz).

Ports:
clk_i  input  1  system clock; single clock domain.
rst_i  input  1  asynchronous, active-low reset.
bus  if_wb.slave  -  Wishbone slave; uses cyc, stb, we, adr[2], dat_i[7:0], dat_o, ack, stall.
ps2_clock  input  1  PS/2 clock line sensed at the pad, asynchronous.
ps2_data  input  1  PS/2 data line sensed at the pad, asynchronous.
ps2_clock_oe  output  1  1 = drive PS/2 clock low; 0 = release.
ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
tx_busy  output  1  high whenever the transmit FSM is not in S_IDLE.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - FSM goes to S_IDLE.
  - ps2_clock_oe = 0, ps2_data_oe = 0 (lines released immediately, even mid-frame).
  - tx_busy = 0, bus.ack = 0, dat_o = 0.
  - All status flags, the shift register, the bit counter and the timer are cleared.
- Line sampling:
  - ps2_clock and ps2_data each pass through a 3-flop synchronizer.
  - A falling edge is sync[2:1] == 2'b10.
- Wishbone timing:
  - stall is tied to 0.
  - ack is a single-cycle pulse, 2 cycles after cyc & stb is first sampled (request latched, then ack).
  - dat_o is valid with ack.
- Register map:
  - adr[2] = 0, write: dat_i[7:0] = byte to send.
  - adr[2] = 0, read: returns {24'h0, last byte written}.
  - adr[2] = 1, read: returns {27'h0, overrun, timeout, nack, ack_ok, tx_busy}.
  - adr[2] = 1, write: acked, no effect.
- Starting a send (write to adr 0):
  - Accepted only in S_IDLE.
  - Latches shreg = {1'b1 stop, parity, byte[7:0]}, 10 bits, where parity = ~^byte (odd parity).
  - Clears ack_ok, nack, timeout and overrun; clears the bit counter and timer.
  - Next state S_INHIBIT.
  - A write while tx_busy is ignored: no state change, overrun is set, the ack is still returned.
- FSM:
  - S_IDLE: both oe = 0.
  - S_INHIBIT: ps2_clock_oe = 1; the timer counts. At timer == INHIBIT_CYCLES-1, set ps2_data_oe = 1 (start bit) and ps2_clock_oe = 0 in the same cycle; clear the timer; go to S_SEND.
  - S_SEND:
    - On each falling edge, ps2_data_oe = ~shreg[0]; shreg shifts right; count++.
    - Falling edges 1-8 carry data bits LSB first, edge 9 carries parity, edge 10 carries stop (data released).
    - After edge 10, go to S_ACK.
  - S_ACK:
    - ps2_data_oe = 0.
    - On the next falling edge, sample synchronized ps2_data: 0 sets ack_ok, 1 sets nack.
    - Go to S_DONE.
  - S_DONE: wait until synchronized ps2_clock == 1, then go to S_IDLE.
- Timeout:
  - The timer runs in S_SEND, S_ACK and S_DONE.
  - At TIMEOUT_CYCLES-1: set timeout, release both lines, go to S_IDLE.
  - A timeout in S_DONE (clock stuck low) still sets timeout; ack_ok/nack keep their values.
- Simultaneous events:
  - A falling edge in the same cycle as the timeout terminal count: timeout wins.
  - A bus read concurrent with a flag update returns the pre-update value.
- Glitches: falling edges seen in S_IDLE or S_INHIBIT are ignored.

Test Plan:
1. Write 0xED; device model clocks at 15 kHz and acks → ps2_clock_oe low for exactly 5000 cycles. Data line bits on edges 1-10 are 1,0,1,1,0,1,1,1, parity 1, stop 1. Status reads 0x02 (ack_ok) and tx_busy drops.
2. Write 0x01; device returns ack bit = 1 → parity bit 0 seen on edge 9, status = 0x04 (nack).
3. Write 0xFF; device never clocks → after INHIBIT_CYCLES + TIMEOUT_CYCLES, status = 0x08 and both oe = 0.
4. Write 0xF3 during edge 4 of an active send → ack returned, status shows overrun = 1. The frame for the original byte completes unchanged.
5. Assert rst_i low at edge 5 of a send → both oe drop to 0 in the same cycle with no clock edge. Status reads 0x00 after reset release.
6. Read adr 0 after writing 0x5A → dat_o = 0x0000005A, ack exactly 2 cycles after stb.
